// File: rtl/zc_cal_sequencer.sv
// rtl/zc_cal_sequencer.sv - clear/calibrate/settle/track sequencer for the I/Q zero-crossing detector pair
// One shared counter serves clear length, calibration samples, settle samples and the tracking timeout.
module zc_cal_sequencer #(
    parameter int WIDTH          = 16,
    parameter int CNT_W          = 32,
    parameter int MAX_LOG_CAL    = 30,
    parameter int CLEAR_CYCLES   = 4,
    parameter int SETTLE_SAMPLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic [4:0]       cfg_log_cal_len,
    input  logic [WIDTH-1:0] cfg_threshold,
    input  logic [CNT_W-1:0] cfg_timeout,
    input  logic             cfg_auto_recal,
    input  logic             sample_valid,
    input  logic             zc_i_valid,
    input  logic             zc_q_valid,
    output logic             zc_clear,
    output logic             zc_init_cal,
    output logic [31:0]      zc_log_cal_len,
    output logic [WIDTH-1:0] zc_threshold,
    output logic             tracking,
    output logic             error,
    output logic             busy,
    output logic [15:0]      recal_count
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CLEAR    = 3'd1,
        S_CAL_GO   = 3'd2,
        S_CAL_WAIT = 3'd3,
        S_SETTLE   = 3'd4,
        S_TRACK    = 3'd5,
        S_ERR      = 3'd6
    } state_t;

    localparam logic [4:0]       MAX_L    = 5'(MAX_LOG_CAL);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] SET_LAST = CNT_W'((SETTLE_SAMPLES > 0) ? SETTLE_SAMPLES - 1 : 0);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, tcnt;
    logic [4:0]         lat_log_q, lat_log_d;
    logic [WIDTH-1:0]   lat_thr_q, lat_thr_d;
    logic [CNT_W-1:0]   lat_to_q, lat_to_d;
    logic               lat_ar_q, lat_ar_d;
    logic [15:0]        recal_q, recal_d;
    logic               clear_q, clear_d, init_q, init_d;
    logic               track_q, track_d, err_q, err_d, busy_q, busy_d;
    logic [4:0]         log_out_q, log_out_d;
    logic [WIDTH-1:0]   thr_out_q, thr_out_d;
    logic               crossing;

    assign crossing = zc_i_valid | zc_q_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            lat_log_q <= '0;
            lat_thr_q <= '0;
            lat_to_q  <= '0;
            lat_ar_q  <= 1'b0;
            recal_q   <= '0;
            clear_q   <= 1'b0;
            init_q    <= 1'b0;
            track_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            log_out_q <= '0;
            thr_out_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lat_log_q <= lat_log_d;
            lat_thr_q <= lat_thr_d;
            lat_to_q  <= lat_to_d;
            lat_ar_q  <= lat_ar_d;
            recal_q   <= recal_d;
            clear_q   <= clear_d;
            init_q    <= init_d;
            track_q   <= track_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            log_out_q <= log_out_d;
            thr_out_q <= thr_out_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lat_log_d = lat_log_q;
        lat_thr_d = lat_thr_q;
        lat_to_d  = lat_to_q;
        lat_ar_d  = lat_ar_q;
        recal_d   = recal_q;
        tcnt      = cnt_q;
        case (state_q)
            S_IDLE, S_ERR: begin
                if (start) begin
                    lat_log_d = (cfg_log_cal_len > MAX_L) ? MAX_L : cfg_log_cal_len;
                    lat_thr_d = cfg_threshold;
                    lat_to_d  = cfg_timeout;
                    lat_ar_d  = cfg_auto_recal;
                    recal_d   = '0;
                    cnt_d     = '0;
                    state_d   = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (cnt_q == CLR_LAST) begin
                    cnt_d   = '0;
                    state_d = S_CAL_GO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_CAL_GO: begin
                if (lat_log_q == 5'd0) begin
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end else begin
                    cnt_d   = CNT_ONE << lat_log_q;
                    state_d = S_CAL_WAIT;
                end
            end
            S_CAL_WAIT: begin
                if (sample_valid) begin
                    if (cnt_q == CNT_ONE) begin
                        cnt_d   = '0;
                        state_d = S_SETTLE;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            S_SETTLE: begin
                if (SETTLE_SAMPLES == 0) begin
                    cnt_d   = '0;
                    state_d = S_TRACK;
                end else if (sample_valid) begin
                    if (cnt_q == SET_LAST) begin
                        cnt_d   = '0;
                        state_d = S_TRACK;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            S_TRACK: begin
                // A crossing clears the count even when a sample arrives in the same cycle.
                if (crossing) begin
                    tcnt = '0;
                end else if (sample_valid && (cnt_q != {CNT_W{1'b1}})) begin
                    tcnt = cnt_q + CNT_ONE;
                end
                cnt_d = tcnt;
                if (!crossing && (lat_to_q != '0) && (tcnt == lat_to_q)) begin
                    cnt_d = '0;
                    if (lat_ar_q) begin
                        state_d = S_CLEAR;
                        if (recal_q != 16'hFFFF) begin
                            recal_d = recal_q + 16'd1;
                        end
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
        if (stop) begin
            cnt_d   = '0;
            state_d = S_IDLE;
        end
    end

    // Outputs are registered, so they are decoded from the next state.
    always_comb begin
        clear_d   = stop || (state_d == S_CLEAR);
        init_d    = (state_d == S_CAL_GO) && (lat_log_d != 5'd0);
        track_d   = (state_d == S_TRACK);
        err_d     = (state_d == S_ERR);
        busy_d    = (state_d != S_IDLE) && (state_d != S_ERR);
        log_out_d = (state_d == S_IDLE) ? 5'd0 : lat_log_d;
        thr_out_d = (state_d == S_IDLE) ? '0 : lat_thr_d;
    end

    assign zc_clear       = clear_q;
    assign zc_init_cal    = init_q;
    assign zc_log_cal_len = {27'd0, log_out_q};
    assign zc_threshold   = thr_out_q;
    assign tracking       = track_q;
    assign error          = err_q;
    assign busy           = busy_q;
    assign recal_count    = recal_q;

endmodule

// File: tb/tb_zc_cal_sequencer.sv
// tb/tb_zc_cal_sequencer.sv - scoreboard bench for zc_cal_sequencer
// Expected output-change events (cycle stamp + output snapshot) are queued by stimulus and popped by a monitor.
module tb_zc_cal_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [4:0]  cfg_log_cal_len = '0;
    logic [15:0] cfg_threshold = '0;
    logic [31:0] cfg_timeout = '0;
    logic        cfg_auto_recal = 1'b0;
    logic        sample_valid = 1'b1;
    logic        zc_i_valid = 1'b0;
    logic        zc_q_valid = 1'b0;
    logic        zc_clear, zc_init_cal, tracking, error, busy;
    logic [31:0] zc_log_cal_len;
    logic [15:0] zc_threshold;
    logic [15:0] recal_count;

    zc_cal_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
        .cfg_log_cal_len(cfg_log_cal_len), .cfg_threshold(cfg_threshold),
        .cfg_timeout(cfg_timeout), .cfg_auto_recal(cfg_auto_recal),
        .sample_valid(sample_valid), .zc_i_valid(zc_i_valid), .zc_q_valid(zc_q_valid),
        .zc_clear(zc_clear), .zc_init_cal(zc_init_cal), .zc_log_cal_len(zc_log_cal_len),
        .zc_threshold(zc_threshold), .tracking(tracking), .error(error), .busy(busy),
        .recal_count(recal_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] cyc;
        logic [4:0]  flags;   // {zc_clear, zc_init_cal, tracking, error, busy}
        logic [15:0] rc;
        logic [31:0] lg;
        logic [15:0] th;
    } ev_t;

    ev_t         exp_q[$];
    int          cyc = 0;
    int          base = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic        mon_en = 1'b0;
    logic [68:0] prev_obs = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en) begin
            logic [68:0] obs;
            ev_t e;
            obs = {zc_clear, zc_init_cal, tracking, error, busy, recal_count, zc_log_cal_len, zc_threshold};
            if (obs != prev_obs) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: got cyc=%0d flags=%b rc=%0d log=%0d thr=%h, required no event",
                             cyc, obs[68:64], obs[63:48], obs[47:16], obs[15:0]);
                end else begin
                    e = exp_q.pop_front();
                    if (e != {32'(cyc), obs}) begin
                        n_fail++;
                        $display("FAIL event: got cyc=%0d flags=%b rc=%0d log=%0d thr=%h, required cyc=%0d flags=%b rc=%0d log=%0d thr=%h",
                                 cyc, obs[68:64], obs[63:48], obs[47:16], obs[15:0],
                                 e.cyc, e.flags, e.rc, e.lg, e.th);
                    end
                end
                prev_obs = obs;
            end
        end
    end

    task automatic push(input int c, input logic [4:0] f, input logic [15:0] rc,
                        input logic [31:0] lg, input logic [15:0] th);
        ev_t e;
        e.cyc = 32'(c); e.flags = f; e.rc = rc; e.lg = lg; e.th = th;
        exp_q.push_back(e);
    endtask

    task automatic arm();
        @(negedge clk);
        base = cyc + 1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_to(input int stamp);
        do @(negedge clk); while (cyc < stamp);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    task automatic async_reset(input int hold);
        @(posedge clk);
        #2;
        push(cyc, 5'b00000, 16'd0, 32'd0, 16'h0);
        reset_n = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_flags", {27'd0, zc_clear, zc_init_cal, tracking, error, busy}, 32'd0);
        check("rst_recal", {16'd0, recal_count}, 32'd0);
        repeat (hold) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int p;
        repeat (3) @(negedge clk);
        check("reset_flags", {27'd0, zc_clear, zc_init_cal, tracking, error, busy}, 32'd0);
        check("reset_recal", {16'd0, recal_count}, 32'd0);
        check("reset_log", zc_log_cal_len, 32'd0);
        check("reset_thr", {16'd0, zc_threshold}, 32'd0);
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // L=4, timeout 100 without auto-recal: full sequence, then ERR after 100 samples
        cfg_log_cal_len = 5'd4; cfg_threshold = 16'h1234; cfg_timeout = 32'd100; cfg_auto_recal = 1'b0;
        arm();
        push(base + 0,   5'b10001, 16'd0, 32'd4, 16'h1234);
        push(base + 4,   5'b01001, 16'd0, 32'd4, 16'h1234);
        push(base + 5,   5'b00001, 16'd0, 32'd4, 16'h1234);
        push(base + 37,  5'b00101, 16'd0, 32'd4, 16'h1234);
        push(base + 137, 5'b00010, 16'd0, 32'd4, 16'h1234);
        pulse_start();
        wait_to(base + 10);
        cfg_threshold = 16'h0FFF;
        wait_to(base + 145);

        // Restart from ERR with L=0 and timeout disabled; then stop from TRACK
        cfg_log_cal_len = 5'd0; cfg_timeout = 32'd0;
        arm();
        push(base + 0,  5'b10001, 16'd0, 32'd0, 16'h0FFF);
        push(base + 4,  5'b00001, 16'd0, 32'd0, 16'h0FFF);
        push(base + 21, 5'b00101, 16'd0, 32'd0, 16'h0FFF);
        pulse_start();
        wait_to(base + 321);
        arm();
        push(base + 0, 5'b10000, 16'd0, 32'd0, 16'h0);
        push(base + 1, 5'b00000, 16'd0, 32'd0, 16'h0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_to(base + 5);

        // Auto-recal: crossings stop, three recalibration passes, crossings resume
        cfg_log_cal_len = 5'd1; cfg_threshold = 16'h00AA; cfg_timeout = 32'd100; cfg_auto_recal = 1'b1;
        zc_q_valid = 1'b1;
        arm();
        push(base + 0,  5'b10001, 16'd0, 32'd1, 16'h00AA);
        push(base + 4,  5'b01001, 16'd0, 32'd1, 16'h00AA);
        push(base + 5,  5'b00001, 16'd0, 32'd1, 16'h00AA);
        push(base + 23, 5'b00101, 16'd0, 32'd1, 16'h00AA);
        pulse_start();
        wait_to(base + 30);
        zc_q_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            p = base + 30 + 100 * k + 23 * (k - 1);
            push(p,      5'b10001, 16'(k), 32'd1, 16'h00AA);
            push(p + 4,  5'b01001, 16'(k), 32'd1, 16'h00AA);
            push(p + 5,  5'b00001, 16'(k), 32'd1, 16'h00AA);
            push(p + 23, 5'b00101, 16'(k), 32'd1, 16'h00AA);
        end
        wait_to(base + 420);
        zc_q_valid = 1'b1;
        wait_to(base + 600);
        check("recal_count", {16'd0, recal_count}, 32'd3);
        check("tracking_after_recal", {31'd0, tracking}, 32'd1);
        zc_q_valid = 1'b0;
        async_reset(2);
        repeat (5) @(negedge clk);

        // Crossing every 50 samples with timeout 60: no timeout for 10000 cycles, then ERR 60 samples after the last
        cfg_log_cal_len = 5'd0; cfg_threshold = 16'h0055; cfg_timeout = 32'd60; cfg_auto_recal = 1'b0;
        arm();
        push(base + 0,  5'b10001, 16'd0, 32'd0, 16'h0055);
        push(base + 4,  5'b00001, 16'd0, 32'd0, 16'h0055);
        push(base + 21, 5'b00101, 16'd0, 32'd0, 16'h0055);
        pulse_start();
        p = 0;
        for (int k = 0; k < 10000; k++) begin
            zc_i_valid = ((k % 50) == 49);
            if (zc_i_valid) p = cyc;
            @(negedge clk);
        end
        zc_i_valid = 1'b0;
        push(p + 61, 5'b00010, 16'd0, 32'd0, 16'h0055);
        wait_to(p + 70);

        // stop and start together in CAL_WAIT: stop wins
        cfg_log_cal_len = 5'd4; cfg_threshold = 16'h0321; cfg_timeout = 32'd0;
        arm();
        push(base + 0, 5'b10001, 16'd0, 32'd4, 16'h0321);
        push(base + 4, 5'b01001, 16'd0, 32'd4, 16'h0321);
        push(base + 5, 5'b00001, 16'd0, 32'd4, 16'h0321);
        pulse_start();
        wait_to(base + 10);
        arm();
        push(base + 0, 5'b10000, 16'd0, 32'd0, 16'h0);
        push(base + 1, 5'b00000, 16'd0, 32'd0, 16'h0);
        stop = 1'b1; start = 1'b1;
        @(negedge clk);
        stop = 1'b0; start = 1'b0;
        wait_to(base + 10);

        // Async reset while in SETTLE: outputs drop at once and stay quiet after release
        cfg_log_cal_len = 5'd0;
        arm();
        push(base + 0, 5'b10001, 16'd0, 32'd0, 16'h0321);
        push(base + 4, 5'b00001, 16'd0, 32'd0, 16'h0321);
        pulse_start();
        wait_to(base + 10);
        async_reset(3);
        repeat (50) @(negedge clk);

        check("pending_events", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
